alu_decode_exec_ctrl: RTL and testbench

Parametrised ALU decode/execute control stage for the pipelined ARM core.
- Decodes all 16 data-processing commands, not just a subset.
- Registers the decoded control into the Execute stage, with stall and flush.
- Holds the architectural NZCV flags register, evaluates the 4-bit condition field, and gates register and flag writes.
- Sits between the Decode-stage main decoder and the Execute-stage ALU/hazard unit.

---
 rtl/alu_ctrl_pkg.sv | 32 +++
 rtl/cond_check.sv | 39 +++
 rtl/alu_decode_exec_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_decode_exec_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU decode/execute control stage
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_AND = 4'h0, CMD_EOR = 4'h1, CMD_SUB = 4'h2, CMD_RSB = 4'h3,
    CMD_ADD = 4'h4, CMD_ADC = 4'h5, CMD_SBC = 4'h6, CMD_RSC = 4'h7,
    CMD_TST = 4'h8, CMD_TEQ = 4'h9, CMD_CMP = 4'hA, CMD_CMN = 4'hB,
    CMD_ORR = 4'hC, CMD_MOV = 4'hD, CMD_BIC = 4'hE, CMD_MVN = 4'hF
  } cmd_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_ORR = 4'h3,
    ALU_EOR = 4'h4, ALU_RSB = 4'h5, ALU_ADC = 4'h6, ALU_SBC = 4'h7,
    ALU_RSC = 4'h8, ALU_MOV = 4'h9, ALU_BIC = 4'hA, ALU_MVN = 4'hB
  } alu_ctrl_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAG_WR_NZ = 2'b10;
  localparam logic [1:0] FLAG_WR_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation against NZCV
module cond_check
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_decode_exec_ctrl.sv
// rtl/alu_decode_exec_ctrl.sv - data-processing decode, Execute control register and NZCV flags
module alu_decode_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         ALU_CTRL_W  = 4,
  parameter bit         CARRY_OPS   = 1'b1,
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic                  i_CLK,
  input  logic                  i_NRESET,
  input  logic [4:0]            i_Funct,
  input  logic                  i_ALU_Op,
  input  logic                  i_Reg_Write_D,
  input  logic [3:0]            i_Cond_D,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  input  logic [3:0]            i_ALU_Flags,
  output logic [ALU_CTRL_W-1:0] o_ALU_Control_E,
  output logic                  o_Carry_In_E,
  output logic                  o_Reg_Write_E,
  output logic [1:0]            o_Flag_Write_E,
  output logic                  o_Cond_Ex_E,
  output logic [3:0]            o_Flags
);

  alu_ctrl_t  d_ctrl;
  logic       d_no_write;
  logic [1:0] d_flag_wr;
  logic       s_bit;
  logic [1:0] arith_fw;
  logic [1:0] logic_fw;

  assign s_bit    = i_Funct[0];
  assign arith_fw = s_bit ? (FLAG_WR_NZ | FLAG_WR_CV) : 2'b00;
  assign logic_fw = s_bit ? FLAG_WR_NZ : 2'b00;

  // Compares never write a register; without S they carry no effect at all.
  always_comb begin
    d_ctrl     = ALU_ADD;
    d_no_write = 1'b0;
    d_flag_wr  = 2'b00;
    if (i_ALU_Op) begin
      case (cmd_t'(i_Funct[4:1]))
        CMD_AND: begin d_ctrl = ALU_AND; d_flag_wr = logic_fw; end
        CMD_EOR: begin d_ctrl = ALU_EOR; d_flag_wr = logic_fw; end
        CMD_SUB: begin d_ctrl = ALU_SUB; d_flag_wr = arith_fw; end
        CMD_RSB: begin d_ctrl = ALU_RSB; d_flag_wr = arith_fw; end
        CMD_ADD: begin d_ctrl = ALU_ADD; d_flag_wr = arith_fw; end
        CMD_ADC: if (CARRY_OPS) begin d_ctrl = ALU_ADC; d_flag_wr = arith_fw; end
                 else d_no_write = 1'b1;
        CMD_SBC: if (CARRY_OPS) begin d_ctrl = ALU_SBC; d_flag_wr = arith_fw; end
                 else d_no_write = 1'b1;
        CMD_RSC: if (CARRY_OPS) begin d_ctrl = ALU_RSC; d_flag_wr = arith_fw; end
                 else d_no_write = 1'b1;
        CMD_TST: begin d_no_write = 1'b1; if (s_bit) begin d_ctrl = ALU_AND; d_flag_wr = FLAG_WR_NZ; end end
        CMD_TEQ: begin d_no_write = 1'b1; if (s_bit) begin d_ctrl = ALU_EOR; d_flag_wr = FLAG_WR_NZ; end end
        CMD_CMP: begin d_no_write = 1'b1; if (s_bit) begin d_ctrl = ALU_SUB; d_flag_wr = 2'b11; end end
        CMD_CMN: begin d_no_write = 1'b1; if (s_bit) begin d_ctrl = ALU_ADD; d_flag_wr = 2'b11; end end
        CMD_ORR: begin d_ctrl = ALU_ORR; d_flag_wr = logic_fw; end
        CMD_MOV: begin d_ctrl = ALU_MOV; d_flag_wr = logic_fw; end
        CMD_BIC: begin d_ctrl = ALU_BIC; d_flag_wr = logic_fw; end
        CMD_MVN: begin d_ctrl = ALU_MVN; d_flag_wr = logic_fw; end
        default: d_ctrl = ALU_ADD;
      endcase
    end
  end

  logic       e_valid;
  alu_ctrl_t  e_ctrl;
  logic       e_no_write;
  logic       e_reg_write;
  logic [1:0] e_flag_wr;
  logic [3:0] e_cond;
  logic [3:0] flags;
  logic       cond_pass;

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      e_valid     <= 1'b0;
      e_ctrl      <= ALU_ADD;
      e_no_write  <= 1'b0;
      e_reg_write <= 1'b0;
      e_flag_wr   <= 2'b00;
      e_cond      <= 4'h0;
    end else if (i_Flush) begin
      e_valid     <= 1'b0;
      e_ctrl      <= ALU_ADD;
      e_no_write  <= 1'b0;
      e_reg_write <= 1'b0;
      e_flag_wr   <= 2'b00;
      e_cond      <= 4'h0;
    end else if (!i_Stall) begin
      e_valid     <= 1'b1;
      e_ctrl      <= d_ctrl;
      e_no_write  <= d_no_write;
      e_reg_write <= i_Reg_Write_D;
      e_flag_wr   <= d_flag_wr;
      e_cond      <= i_Cond_D;
    end
  end

  cond_check u_cond_check (
    .cond  (e_cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign o_Cond_Ex_E     = e_valid & cond_pass;
  assign o_Reg_Write_E   = o_Cond_Ex_E & e_reg_write & !e_no_write;
  assign o_Flag_Write_E  = e_flag_wr & {2{o_Cond_Ex_E}};
  assign o_ALU_Control_E = ALU_CTRL_W'(e_ctrl);
  assign o_Carry_In_E    = flags[FLAG_C];
  assign o_Flags         = flags;

  // A stalled instruction stays in E, so only its final unstalled cycle commits flags.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      flags <= FLAGS_RESET;
    end else if (o_Cond_Ex_E && !i_Stall) begin
      if (o_Flag_Write_E[1]) flags[3:2] <= i_ALU_Flags[3:2];
      if (o_Flag_Write_E[0]) flags[1:0] <= i_ALU_Flags[1:0];
    end
  end

endmodule

// File: tb/tb_alu_decode_exec_ctrl.sv
// tb/tb_alu_decode_exec_ctrl.sv - directed scoreboard bench for alu_decode_exec_ctrl
module tb_alu_decode_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] funct;
  logic       alu_op;
  logic       reg_write_d;
  logic [3:0] cond_d;
  logic       stall;
  logic       flush;
  logic [3:0] alu_flags;

  logic [3:0] a_ctrl, b_ctrl;
  logic       a_cin, b_cin;
  logic       a_rw, b_rw;
  logic [1:0] a_fw, b_fw;
  logic       a_cex, b_cex;
  logic [3:0] a_flags, b_flags;

  always #5 clk = ~clk;

  alu_decode_exec_ctrl #(.ALU_CTRL_W(4), .CARRY_OPS(1'b1), .FLAGS_RESET(4'b0000)) dut_a (
    .i_CLK(clk), .i_NRESET(rst_n), .i_Funct(funct), .i_ALU_Op(alu_op),
    .i_Reg_Write_D(reg_write_d), .i_Cond_D(cond_d), .i_Stall(stall), .i_Flush(flush),
    .i_ALU_Flags(alu_flags), .o_ALU_Control_E(a_ctrl), .o_Carry_In_E(a_cin),
    .o_Reg_Write_E(a_rw), .o_Flag_Write_E(a_fw), .o_Cond_Ex_E(a_cex), .o_Flags(a_flags)
  );

  alu_decode_exec_ctrl #(.ALU_CTRL_W(4), .CARRY_OPS(1'b0), .FLAGS_RESET(4'b0000)) dut_b (
    .i_CLK(clk), .i_NRESET(rst_n), .i_Funct(funct), .i_ALU_Op(alu_op),
    .i_Reg_Write_D(reg_write_d), .i_Cond_D(cond_d), .i_Stall(stall), .i_Flush(flush),
    .i_ALU_Flags(alu_flags), .o_ALU_Control_E(b_ctrl), .o_Carry_In_E(b_cin),
    .o_Reg_Write_E(b_rw), .o_Flag_Write_E(b_fw), .o_Cond_Ex_E(b_cex), .o_Flags(b_flags)
  );

  typedef struct {
    string      tag;
    logic [3:0] ctrl;
    logic       chk_ctrl;
    logic       rw;
    logic [1:0] fw;
    logic       cex;
    logic [3:0] flags;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] f, input logic op, input logic rw,
                      input logic [3:0] cond, input logic st, input logic fl, input logic [3:0] af,
                      input logic [3:0] e_ctrl, input logic e_chk, input logic e_rw,
                      input logic [1:0] e_fw, input logic e_cex, input logic [3:0] e_flags);
    exp_t e;
    @(negedge clk);
    funct = f; alu_op = op; reg_write_d = rw; cond_d = cond;
    stall = st; flush = fl; alu_flags = af;
    e.tag = tag; e.ctrl = e_ctrl; e.chk_ctrl = e_chk; e.rw = e_rw;
    e.fw = e_fw; e.cex = e_cex; e.flags = e_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk_ctrl) chk({e.tag, "_ctrl"}, {4'h0, a_ctrl}, {4'h0, e.ctrl});
    chk({e.tag, "_rw"},    {7'h0, a_rw},    {7'h0, e.rw});
    chk({e.tag, "_fw"},    {6'h0, a_fw},    {6'h0, e.fw});
    chk({e.tag, "_cex"},   {7'h0, a_cex},   {7'h0, e.cex});
    chk({e.tag, "_flags"}, {4'h0, a_flags}, {4'h0, e.flags});
    chk({e.tag, "_cin"},   {7'h0, a_cin},   {7'h0, e.flags[1]});
  endtask

  initial begin
    rst_n = 1'b0; funct = 5'h0; alu_op = 1'b0; reg_write_d = 1'b0; cond_d = 4'hE;
    stall = 1'b0; flush = 1'b0; alu_flags = 4'h0;
    #12;
    chk("rst_flags", {4'h0, a_flags}, 8'h00);
    chk("rst_rw",    {7'h0, a_rw},    8'h00);
    chk("rst_cex",   {7'h0, a_cex},   8'h00);
    chk("rst_fw",    {6'h0, a_fw},    8'h00);
    chk("rst_ctrl",  {4'h0, a_ctrl},  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    //    tag        funct        op rw cond  st fl aflg   ctrl chk rw fw     cex flags
    step("idle",     {4'h0,1'b0}, 0, 0, 4'hE, 0, 1, 4'h0,  4'h0, 1, 0, 2'b00, 0, 4'h0);
    step("adds",     {4'h4,1'b1}, 1, 1, 4'hE, 0, 0, 4'h0,  4'h0, 1, 1, 2'b11, 1, 4'h0);
    step("cmps",     {4'hA,1'b1}, 1, 1, 4'hE, 0, 0, 4'h6,  4'h1, 1, 0, 2'b11, 1, 4'h6);
    step("addeq_t",  {4'h4,1'b0}, 1, 1, 4'h0, 0, 0, 4'h4,  4'h0, 1, 1, 2'b00, 1, 4'h4);
    step("cmps2",    {4'hA,1'b1}, 1, 1, 4'hE, 0, 0, 4'h0,  4'h1, 1, 0, 2'b11, 1, 4'h4);
    step("addeq_f",  {4'h4,1'b0}, 1, 1, 4'h0, 0, 0, 4'h0,  4'h0, 1, 0, 2'b00, 0, 4'h0);
    step("adds_gate",{4'h4,1'b1}, 1, 1, 4'hE, 0, 0, 4'hF,  4'h0, 1, 1, 2'b11, 1, 4'h0);
    step("ands",     {4'h0,1'b1}, 1, 1, 4'hE, 0, 0, 4'h3,  4'h2, 1, 1, 2'b10, 1, 4'h3);
    step("adcs",     {4'h5,1'b1}, 1, 1, 4'hE, 0, 0, 4'h8,  4'h6, 1, 1, 2'b11, 1, 4'hB);
    for (int i = 0; i < 3; i++)
      step("stall",  {4'h2,1'b1}, 1, 1, 4'hE, 1, 0, 4'h5,  4'h6, 1, 1, 2'b11, 1, 4'hB);
    step("unstall",  {4'h2,1'b1}, 1, 1, 4'hE, 0, 0, 4'h5,  4'h1, 1, 1, 2'b11, 1, 4'h5);
    step("flush_st", {4'hC,1'b1}, 1, 1, 4'hE, 1, 1, 4'hF,  4'h0, 0, 0, 2'b00, 0, 4'h5);
    step("add_nv",   {4'h4,1'b0}, 1, 1, 4'hF, 0, 0, 4'h0,  4'h0, 1, 0, 2'b00, 0, 4'h5);
    step("sbcs",     {4'h6,1'b1}, 1, 1, 4'hE, 0, 0, 4'h0,  4'h7, 1, 1, 2'b11, 1, 4'h5);
    chk("nocarry_ctrl", {4'h0, b_ctrl}, 8'h00);
    chk("nocarry_rw",   {7'h0, b_rw},   8'h00);
    chk("nocarry_fw",   {6'h0, b_fw},   8'h00);
    step("tst_nop",  {4'h8,1'b0}, 1, 1, 4'hE, 0, 0, 4'hF,  4'h0, 1, 0, 2'b00, 1, 4'hF);
    step("movs_le",  {4'hD,1'b1}, 1, 1, 4'hD, 0, 0, 4'h0,  4'h9, 1, 1, 2'b10, 1, 4'hF);
    step("non_dp",   {4'h0,1'b0}, 0, 1, 4'hE, 0, 0, 4'h0,  4'h0, 1, 1, 2'b00, 1, 4'h3);
    step("adds_gt",  {4'h4,1'b1}, 1, 1, 4'hC, 0, 0, 4'h0,  4'h0, 1, 0, 2'b00, 0, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
